booth_radix4_seq_mult: RTL

Sequential, parametrised radix-4 Booth multiplier for the CPU datapath's MUL/MULU instructions. It retires one bit-pair-recoded digit per clock, so a WIDTH×WIDTH multiply costs about WIDTH/2 cycles of a single adder rather than a full combinational array. It sits beside the ALU, is started by the control unit, and delivers a 2·WIDTH-bit product to the HI/LO registers through a start/busy/done handshake.

---
 rtl/booth_pkg.sv | 24 ++
 rtl/booth_digit_sel.sv | 37 +++
 rtl/booth_radix4_seq_mult.sv | 114 +++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier.
// State encoding, recoded-digit encoding and digit-count helper.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } digit_e;

  // One extra digit keeps unsigned operands exact.
  function automatic int num_digits(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_digit_sel.sv
// Radix-4 Booth digit recoder: maps {b[1:0], prev} to the addend
// (0, +-mcand, +-2*mcand) at full accumulator width.
module booth_digit_sel
  import booth_pkg::*;
#(
  parameter int W = 34
) (
  input  logic [2:0]   recode,
  input  logic [W-1:0] mcand,
  output logic [W-1:0] term
);

  digit_e digit;

  always_comb begin
    digit = ZERO;
    unique case (recode)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
  end

  always_comb begin
    term = '0;
    unique case (1'b1)
      (digit == POS1): term = mcand;
      (digit == POS2): term = mcand << 1;
      (digit == NEG1): term = '0 - mcand;
      (digit == NEG2): term = '0 - (mcand << 1);
      default:         term = '0;
    endcase
  end

endmodule

// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier, one digit per clock.
// BOOTH_EARLY_TERM_EN enables exit once remaining digits are zero.
module booth_radix4_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int N  = num_digits(WIDTH);
  localparam int CW = $clog2(N + 1);
  localparam int AW = 2 * WIDTH + 2;
  localparam int BW = WIDTH + 2;

  state_e             state, state_n;
  logic [AW-1:0]      acc, acc_n;
  logic [AW-1:0]      mcand, mcand_n;
  logic [AW-1:0]      term;
  logic [BW-1:0]      mplier, mplier_n;
  logic               prev, prev_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [2*WIDTH-1:0] product_n;
  logic               done_n;
  logic               sa, sb;
  logic               last;

  booth_digit_sel #(
    .W(AW)
  ) u_sel (
    .recode({mplier[1:0], prev}),
    .mcand (mcand),
    .term  (term)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      prev    <= 1'b0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      mcand   <= mcand_n;
      mplier  <= mplier_n;
      prev    <= prev_n;
      cnt     <= cnt_n;
      product <= product_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    mcand_n   = mcand;
    mplier_n  = mplier;
    prev_n    = prev;
    cnt_n     = cnt;
    product_n = product;
    done_n    = 1'b0;
    sa        = signed_mode & multiplicand[WIDTH-1];
    sb        = signed_mode & multiplier[WIDTH-1];
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          acc_n    = '0;
          mcand_n  = {{(AW-WIDTH){sa}}, multiplicand};
          mplier_n = {{2{sb}}, multiplier};
          prev_n   = 1'b0;
          cnt_n    = CW'(N);
          state_n  = CALC;
        end
      end
      CALC: begin
        acc_n    = acc + term;
        mcand_n  = mcand << 2;
        mplier_n = {{2{mplier[BW-1]}}, mplier[BW-1:2]};
        prev_n   = mplier[1];
        cnt_n    = cnt - 1'b1;
        last     = (cnt == CW'(1));
`ifdef BOOTH_EARLY_TERM_EN
        // Uniform remaining bits recode to all-zero digits.
        last = last | (&{mplier_n, prev_n}) | ~(|{mplier_n, prev_n});
`endif
        if (last) state_n = DONE;
      end
      DONE: begin
        product_n = acc[2*WIDTH-1:0];
        done_n    = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // The done cycle is already IDLE, so busy is stretched to cover it.
  assign busy = (state != IDLE) | done;

endmodule
